credit_tx: RTL and testbench

CREDIT_TX -- requirements
Module: credit_tx

---
 rtl/credit_tx.sv | 83 ++++++++
 tb/tb_credit_tx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/credit_tx.sv
// Credit-based link transmitter: forwards upstream beats onto a no-backpressure
// link, spending one credit per beat and recovering one per receiver credit pulse.
module credit_tx #(
  parameter int T_w       = 1,
  parameter int MaxCredit = 2,
  localparam int CW       = $clog2(MaxCredit + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic [T_w-1:0] data_i,
  output logic          valid_o,
  output logic [T_w-1:0] data_o,
  input  logic          credit_i,
  output logic [CW-1:0] credit_cnt_o,
  output logic          idle_o,
  output logic          overflow_o
);

  localparam logic [CW-1:0] MaxCnt = CW'(MaxCredit);

  logic [CW-1:0]  cnt_q;
  logic           vld_p1;
  logic [T_w-1:0] data_p1;
  logic           ovf_q;
  logic           xfer;
  logic           ovf_set;

  // A returned credit at full count is saturated away; the caller flags it.
  function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] cnt,
                                             input logic take,
                                             input logic give);
    logic [CW-1:0] res;
    res = cnt;
    if (take && !give) begin
      res = cnt - CW'(1);
    end else if (give && !take && (cnt != MaxCnt)) begin
      res = cnt + CW'(1);
    end
    return res;
  endfunction

  assign ready_o = (cnt_q != '0) && !clr_i;
  assign xfer    = valid_i && ready_o;
  assign ovf_set = credit_i && !xfer && (cnt_q == MaxCnt);

  // Stage p0 -> p1: control state (credits, link valid, sticky overflow)
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= MaxCnt;
      vld_p1 <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (clr_i) begin
      cnt_q  <= MaxCnt;
      vld_p1 <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_next(cnt_q, xfer, credit_i);
      vld_p1 <= xfer;
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Stage p0 -> p1: payload, loaded only on a transfer so it holds otherwise
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_p1 <= '0;
    end else if (xfer) begin
      data_p1 <= data_i;
    end
  end

  assign valid_o      = vld_p1;
  assign data_o       = data_p1;
  assign credit_cnt_o = cnt_q;
  assign overflow_o   = ovf_q;
  assign idle_o       = (cnt_q == MaxCnt) && !vld_p1;

endmodule

// File: tb/tb_credit_tx.sv
// Randomized scoreboard bench for credit_tx with a 2-entry model receiver.
module tb_credit_tx;

  localparam int T_w = 8;
  localparam int MaxCredit = 2;
  localparam int CW = $clog2(MaxCredit + 1);

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          clr_i = 1'b0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [T_w-1:0] data_i = '0;
  logic          valid_o;
  logic [T_w-1:0] data_o;
  logic          credit_i = 1'b0;
  logic [CW-1:0] credit_cnt_o;
  logic          idle_o;
  logic          overflow_o;

  credit_tx #(.T_w(T_w), .MaxCredit(MaxCredit)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i),
    .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
    .valid_o(valid_o), .data_o(data_o), .credit_i(credit_i),
    .credit_cnt_o(credit_cnt_o), .idle_o(idle_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: credit count, sticky overflow, beat on link, beat queue
  int             credits = MaxCredit;
  bit             ovf_m = 0;
  bit             link_m = 0;
  logic [T_w-1:0] exp_q[$];
  logic [T_w-1:0] last_data = '0;
  bit             rx_en = 0;
  int             rx_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    credits = MaxCredit;
    ovf_m   = 0;
    link_m  = 0;
    exp_q.delete();
    rx_cnt  = 0;
  endtask

  // One clock cycle: drive at posedge+1, check ready before edge, check state after.
  task automatic step(input logic v, input logic [T_w-1:0] d, input logic c, input logic clr);
    bit x;
    valid_i = v; data_i = d; credit_i = c; clr_i = clr;
    #1;
    chk("ready", 32'(ready_o), 32'(credits > 0 && !clr));
    x = v && credits > 0 && !clr;
    if (x) exp_q.push_back(d);
    if (clr) begin
      credits = MaxCredit; ovf_m = 0; link_m = 0;
    end else begin
      if (x && !c) credits--;
      else if (c && !x) begin
        if (credits == MaxCredit) ovf_m = 1;
        else credits++;
      end
      link_m = x;
    end
    @(posedge clk_i); #1;
    valid_i = 1'b0; credit_i = 1'b0; clr_i = 1'b0;
    chk("cnt", 32'(credit_cnt_o), 32'(credits));
    chk("overflow", 32'(overflow_o), 32'(ovf_m));
    chk("idle", 32'(idle_o), 32'(credits == MaxCredit && !link_m));
  endtask

  // Monitor: every link beat must be the next expected one; data holds otherwise.
  initial begin
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        last_data = '0;
      end else if (valid_o) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL beat: unexpected beat %0h, nothing outstanding", data_o);
        end else begin
          logic [T_w-1:0] e;
          e = exp_q.pop_front();
          if (data_o !== e) begin
            n_err++;
            $display("FAIL beat: got %0h expected %0h", data_o, e);
          end
        end
        last_data = data_o;
        if (rx_en) begin
          rx_cnt++;
          chk("rx_fill", 32'(rx_cnt <= MaxCredit), 32'd1);
        end
      end else begin
        chk("data_hold", 32'(data_o), 32'(last_data));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [T_w-1:0] rd;
    bit             rv;
    bit             rc;
    int             drain;

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_cnt", 32'(credit_cnt_o), 32'(MaxCredit));
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_data", 32'(data_o), 32'd0);
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_idle", 32'(idle_o), 32'd1);
    chk("rst_ovf", 32'(overflow_o), 32'd0);
    rst_ni = 1'b1;

    // Burst until credits run out; 0xA3 held
    step(1, 8'hA1, 0, 0);
    step(1, 8'hA2, 0, 0);
    step(1, 8'hA3, 0, 0);
    step(1, 8'hA3, 0, 0);
    // Credit release, then 0xA3 goes
    step(1, 8'hA3, 1, 0);
    step(1, 8'hA3, 0, 0);
    step(0, 8'hA3, 0, 0);
    // Simultaneous xfer and credit at cnt 1
    step(0, 8'h00, 1, 0);
    step(1, 8'h55, 1, 0);
    step(0, 8'h55, 0, 0);
    // Back to full, xfer with credit at full: no overflow
    step(0, 8'h00, 1, 0);
    step(1, 8'h66, 1, 0);
    step(0, 8'h66, 0, 0);
    // Overflow, sticky, cleared by clr; clr blocks xfer and ignores credit
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 0);
    step(1, 8'h77, 1, 1);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 1);
    // clr with a beat in flight drops it from the link
    step(1, 8'h88, 0, 0);
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 0);

    // Reset mid-stream with cnt 0 and valid_o high
    step(1, 8'hB1, 0, 0);
    step(1, 8'hB2, 0, 0);
    chk("pre_rst_valid", 32'(valid_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("arst_valid", 32'(valid_o), 32'd0);
    chk("arst_data", 32'(data_o), 32'd0);
    chk("arst_cnt", 32'(credit_cnt_o), 32'(MaxCredit));
    chk("arst_ready", 32'(ready_o), 32'd1);
    chk("arst_idle", 32'(idle_o), 32'd1);
    model_reset();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    step(1, 8'hC1, 0, 0);
    step(0, 8'h00, 1, 0);

    // Random traffic against the model receiver
    step(0, 8'h00, 0, 1);
    rx_en = 1; rx_cnt = 0;
    rv = 0; rd = '0;
    for (int i = 0; i < 600; i++) begin
      if (!(rv && credits == 0)) begin
        rv = ($urandom_range(0, 3) != 0);
        rd = 8'($urandom);
      end
      rc = 0;
      if (rx_cnt > 0 && $urandom_range(0, 2) != 0) begin
        rc = 1;
        rx_cnt--;
      end
      step(rv, rd, rc, 0);
      if (rv && credits >= 0 && exp_q.size() > 0 && exp_q[exp_q.size()-1] == rd) rv = 0;
    end
    drain = 0;
    while ((exp_q.size() != 0 || rx_cnt != 0) && drain < 20) begin
      rc = 0;
      if (rx_cnt > 0) begin
        rc = 1;
        rx_cnt--;
      end
      step(0, 8'h00, rc, 0);
      drain++;
    end
    step(0, 8'h00, 0, 0);
    chk("lost_beats", 32'(exp_q.size()), 32'd0);
    chk("final_cnt", 32'(credit_cnt_o), 32'(MaxCredit));
    chk("final_ovf", 32'(overflow_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
